rwt_adc_pack: RTL and testbench
===============================

RWT_ADC_PACK -- requirements
Module: rwt_adc_pack

Interface
REQ-001 SHALL have parameter MAX_CHANNELS, default 4, number of 16-bit channel lanes (1..8).
REQ-002 SHALL have port adc_clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port adc_rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port adc_data  input  MAX_CHANNELS*16  channel i in bits [16*i +: 16].
REQ-005 SHALL have port adc_enable  input  MAX_CHANNELS  per-channel enable.
REQ-006 SHALL have port adc_valid  input  MAX_CHANNELS  per-channel valid; a sample beat is any cycle with (adc_valid & adc_enable) != 0.
REQ-007 SHALL have port pack_data  output  MAX_CHANNELS*16  densely packed samples, oldest in bits [15:0].
REQ-008 SHALL have port pack_valid  output  1  pack_data holds a complete word.
REQ-009 SHALL have port pack_ready  input  1  consumer accepts the word when pack_valid && pack_ready.
REQ-010 SHALL have port pack_sof  output  1  high with the first word after a (re)start.
REQ-011 SHALL have port overflow  output  1  sticky; a completed word was dropped.
REQ-012 SHALL have port overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-013 SHALL, per beat, compact enabled channel samples in ascending channel order and append N = popcount(adc_enable) samples to an accumulator of 2*MAX_CHANNELS samples.
REQ-014 SHALL track fill count 0..2*MAX_CHANNELS-1 in $clog2(2*MAX_CHANNELS) bits; on fill >= MAX_CHANNELS, move the lowest MAX_CHANNELS samples to the output register and subtract MAX_CHANNELS.
REQ-015 SHALL present a completed word on pack_data/pack_valid the cycle after the completing beat (latency 1).
REQ-016 SHALL hold pack_data stable while pack_valid && !pack_ready.
REQ-017 SHALL, when a word completes while the output register is full and not being accepted that cycle, drop the new word, keep the held word, and set overflow.
REQ-018 SHALL accept a new word into the output register in the same cycle the held word is accepted (no bubble).
REQ-019 SHALL use states IDLE (N == 0), PACK (N > 0); IDLE->PACK when adc_enable becomes nonzero; PACK->IDLE when it becomes zero.
REQ-020 SHALL, on any change of adc_enable, discard accumulator contents (fill = 0) in that cycle and treat the new value as a restart; the held output word is not discarded.
REQ-021 SHALL assert pack_sof with the first word emitted after reset or restart, and not with subsequent words.
REQ-022 SHALL, if overflow_clr and a new drop coincide, leave overflow set.
REQ-023 SHALL ignore adc_data of disabled channels and beats in IDLE.

Reset
REQ-024 SHALL, with adc_rstn low, drive pack_data=0, pack_valid=0, pack_sof=0, overflow=0, fill=0, state=IDLE.
REQ-025 SHALL, on reset mid-word, discard partial and held words; first word after release carries pack_sof.

Configuration
REQ-026 SHALL, with RWT_ADC_PACK_STATS_EN defined, add output word_count (32 bits, increments per accepted word, wraps at 2^32, reset 0) and drop_count (16 bits, saturating at 0xFFFF, reset 0).
REQ-027 SHALL, without RWT_ADC_PACK_STATS_EN, omit both ports and their counters.

Structure
REQ-028 SHALL place the state enum (IDLE, PACK) and a popcount function in shared package rwt_adc_pkg.
REQ-029 SHALL implement channel compaction in sub-module rwt_adc_compact (data, enable -> compacted samples, N).

Verification
REQ-030 SHALL check: MAX_CHANNELS=4, enable=4'hF, beats 0x0001..0x0004 then 0x0005..0x0008, ready=1 -> words {4,3,2,1}, {8,7,6,5} at latency 1, sof only on first.
REQ-031 SHALL check: enable=4'b0101, beats ch0/ch2 = (A,B),(C,D) -> one word {D,C,B,A} after second beat.
REQ-032 SHALL check: enable=4'b0001, ready=0 for 8 beats of 0x0010..0x0017 -> held word {13,12,11,10}, overflow=1, drop_count=1 with STATS.
REQ-033 SHALL check: enable 4'b0011 -> 4'b1111 after one beat -> partial discarded, next word all from new config, sof=1.
REQ-034 SHALL check: adc_rstn low for 1 cycle with fill=3 -> all outputs 0, next word has sof=1.
REQ-035 SHALL check: overflow_clr with no concurrent drop clears overflow next cycle; concurrent drop keeps it 1.

Source files
------------

// File: rtl/rwt_adc_pkg.sv
// Shared types and helpers for the ADC sample packer.
// Holds the packer state encoding and the channel popcount.
package rwt_adc_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } state_t;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rwt_adc_compact.sv
// Compacts enabled channel samples into the low lanes, ascending channel order.
// Purely combinational; no backpressure.
module rwt_adc_compact
    import rwt_adc_pkg::*;
#(
    parameter int MAX_CHANNELS = 4
) (
    input  logic [MAX_CHANNELS*SAMPLE_W-1:0]   data,
    input  logic [MAX_CHANNELS-1:0]            enable,
    output logic [MAX_CHANNELS*SAMPLE_W-1:0]   cmp_data,
    output logic [$clog2(MAX_CHANNELS+1)-1:0]  cmp_n
);

    localparam int NW = $clog2(MAX_CHANNELS + 1);

    always_comb begin
        int pos;
        cmp_data = '0;
        pos      = 0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (enable[i]) begin
                cmp_data[pos*SAMPLE_W +: SAMPLE_W] = data[i*SAMPLE_W +: SAMPLE_W];
                pos = pos + 1;
            end
        end
    end

    assign cmp_n = NW'(popcount(8'(enable)));

endmodule

// File: rtl/rwt_adc_pack.sv
// Packs enabled ADC channel samples into MAX_CHANNELS-wide words; one-cycle latency.
// Single output register with valid/ready; a word completing while it is stalled is dropped (sticky overflow).
// Optional word/drop statistics ports when RWT_ADC_PACK_STATS_EN is defined.
module rwt_adc_pack
    import rwt_adc_pkg::*;
#(
    parameter int MAX_CHANNELS = 4
) (
    input  logic                             adc_clk,
    input  logic                             adc_rstn,
    input  logic [MAX_CHANNELS*SAMPLE_W-1:0] adc_data,
    input  logic [MAX_CHANNELS-1:0]          adc_enable,
    input  logic [MAX_CHANNELS-1:0]          adc_valid,
    output logic [MAX_CHANNELS*SAMPLE_W-1:0] pack_data,
    output logic                             pack_valid,
    input  logic                             pack_ready,
    output logic                             pack_sof,
    output logic                             overflow,
    input  logic                             overflow_clr
`ifdef RWT_ADC_PACK_STATS_EN
    ,
    output logic [31:0]                      word_count,
    output logic [15:0]                      drop_count
`endif
);

    localparam int M  = MAX_CHANNELS;
    localparam int DW = M * SAMPLE_W;
    localparam int AW = 2 * M;
    localparam int FW = $clog2(AW);
    localparam int NW = $clog2(M + 1);

    state_t                state, state_nxt;
    logic                  pack_en;
    logic [M-1:0]          en_q;
    logic                  en_chg;
    logic                  beat;
    logic [DW-1:0]         cmp_data;
    logic [NW-1:0]         cmp_n;
    logic [SAMPLE_W-1:0]   acc     [AW];
    logic [SAMPLE_W-1:0]   acc_nxt [AW];
    logic [FW-1:0]         fill, fill_nxt;
    logic                  word_done;
    logic [DW-1:0]         word_dat;
    logic                  sof_pend;
    logic                  load, drop;

    rwt_adc_compact #(.MAX_CHANNELS(M)) u_compact (
        .data     (adc_data),
        .enable   (adc_enable),
        .cmp_data (cmp_data),
        .cmp_n    (cmp_n)
    );

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state <= IDLE;
            en_q  <= '0;
        end else begin
            state <= state_nxt;
            en_q  <= adc_enable;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (adc_enable != '0) state_nxt = PACK;
            PACK:    if (adc_enable == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pack_en = (state == PACK);
    end

    // The beat arriving with a changed enable is not packed: it is the restart cycle.
    assign en_chg = (adc_enable != en_q);
    assign beat   = pack_en && !en_chg && ((adc_valid & adc_enable) != '0);

    always_comb begin
        int sum;
        int idx;
        acc_nxt   = acc;
        fill_nxt  = fill;
        word_done = 1'b0;
        word_dat  = '0;
        sum       = 0;
        idx       = 0;
        if (en_chg) begin
            fill_nxt = '0;
        end else if (beat) begin
            for (int k = 0; k < M; k++) begin
                idx = int'(fill) + k;
                if (k < int'(cmp_n) && idx < AW) begin
                    acc_nxt[idx] = cmp_data[k*SAMPLE_W +: SAMPLE_W];
                end
            end
            sum = int'(fill) + int'(cmp_n);
            if (sum >= M) begin
                word_done = 1'b1;
                for (int k = 0; k < M; k++) begin
                    word_dat[k*SAMPLE_W +: SAMPLE_W] = acc_nxt[k];
                end
                for (int j = 0; j < M; j++) begin
                    acc_nxt[j] = acc_nxt[j+M];
                end
                for (int j = M; j < AW; j++) begin
                    acc_nxt[j] = '0;
                end
                sum = sum - M;
            end
            fill_nxt = FW'(sum);
        end
    end

    assign load = word_done && (!pack_valid || pack_ready);
    assign drop = word_done && pack_valid && !pack_ready;

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            for (int j = 0; j < AW; j++) acc[j] <= '0;
            fill       <= '0;
            pack_data  <= '0;
            pack_valid <= 1'b0;
            pack_sof   <= 1'b0;
            sof_pend   <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            acc  <= acc_nxt;
            fill <= fill_nxt;
            if (load) begin
                pack_data  <= word_dat;
                pack_valid <= 1'b1;
                pack_sof   <= sof_pend;
            end else if (pack_valid && pack_ready) begin
                pack_valid <= 1'b0;
                pack_sof   <= 1'b0;
            end
            if (en_chg)    sof_pend <= 1'b1;
            else if (load) sof_pend <= 1'b0;
            // A drop in the same cycle as a clear wins so no loss goes unreported.
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

`ifdef RWT_ADC_PACK_STATS_EN
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            word_count <= '0;
            drop_count <= '0;
        end else begin
            if (pack_valid && pack_ready)     word_count <= word_count + 32'd1;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rwt_adc_pack.sv
// Bench for rwt_adc_pack: directed scenarios plus randomized traffic against a sample-queue model.
module tb_rwt_adc_pack;

    localparam int M  = 4;
    localparam int DW = M * 16;

    logic            adc_clk = 1'b0;
    logic            adc_rstn;
    logic [DW-1:0]   adc_data;
    logic [M-1:0]    adc_enable;
    logic [M-1:0]    adc_valid;
    logic [DW-1:0]   pack_data;
    logic            pack_valid;
    logic            pack_ready;
    logic            pack_sof;
    logic            overflow;
    logic            overflow_clr;
`ifdef RWT_ADC_PACK_STATS_EN
    logic [31:0]     word_count;
    logic [15:0]     drop_count;
`endif

    always #5 adc_clk = ~adc_clk;

    rwt_adc_pack #(.MAX_CHANNELS(M)) dut (
        .adc_clk      (adc_clk),
        .adc_rstn     (adc_rstn),
        .adc_data     (adc_data),
        .adc_enable   (adc_enable),
        .adc_valid    (adc_valid),
        .pack_data    (pack_data),
        .pack_valid   (pack_valid),
        .pack_ready   (pack_ready),
        .pack_sof     (pack_sof),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef RWT_ADC_PACK_STATS_EN
        ,
        .word_count   (word_count),
        .drop_count   (drop_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of samples plus one held output word.
    logic [15:0]  mq[$];
    logic [M-1:0] m_en;
    logic         m_vld, m_sof, m_sofp, m_ovf;
    logic [63:0]  m_dat;
    int unsigned  m_words;
    int           m_drops;

    task automatic model_reset();
        mq.delete();
        m_en    = '0;
        m_vld   = 1'b0;
        m_sof   = 1'b0;
        m_sofp  = 1'b1;
        m_ovf   = 1'b0;
        m_dat   = '0;
        m_words = 0;
        m_drops = 0;
    endtask

    task automatic model_step(input logic [M-1:0] en, input logic [M-1:0] vld,
                              input logic [DW-1:0] dat, input logic rdy, input logic clr);
        logic        done;
        logic        dropped;
        logic [63:0] w;
        done    = 1'b0;
        dropped = 1'b0;
        w       = '0;
        if (en != m_en) begin
            mq.delete();
        end else if ((vld & en) != '0) begin
            for (int ch = 0; ch < M; ch++)
                if (en[ch]) mq.push_back(dat[16*ch +: 16]);
            if (mq.size() >= M) begin
                for (int k = 0; k < M; k++) w[16*k +: 16] = mq.pop_front();
                done = 1'b1;
            end
        end
        if (m_vld && rdy) m_words++;
        if (done) begin
            if (!m_vld || rdy) begin
                m_dat  = w;
                m_vld  = 1'b1;
                m_sof  = m_sofp;
                m_sofp = 1'b0;
            end else begin
                dropped = 1'b1;
                m_ovf   = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
            m_sof = 1'b0;
        end
        if (clr && !dropped) m_ovf = 1'b0;
        if (en != m_en) m_sofp = 1'b1;
        m_en = en;
    endtask

    task automatic compare_all();
        chk("pack_valid", 64'(pack_valid), 64'(m_vld));
        chk("pack_data",  pack_data,       m_dat);
        chk("pack_sof",   64'(pack_sof),   64'(m_sof));
        chk("overflow",   64'(overflow),   64'(m_ovf));
`ifdef RWT_ADC_PACK_STATS_EN
        chk("word_count", 64'(word_count), 64'(m_words));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
`endif
    endtask

    // Called at a falling edge: drive, advance model, sample at next falling edge.
    task automatic step(input logic [M-1:0] en, input logic [M-1:0] vld,
                        input logic [DW-1:0] dat, input logic rdy, input logic clr);
        adc_enable   = en;
        adc_valid    = vld;
        adc_data     = dat;
        pack_ready   = rdy;
        overflow_clr = clr;
        model_step(en, vld, dat, rdy, clr);
        @(posedge adc_clk);
        @(negedge adc_clk);
        compare_all();
    endtask

    task automatic do_reset();
        adc_rstn     = 1'b0;
        adc_enable   = '0;
        adc_valid    = '0;
        adc_data     = '0;
        pack_ready   = 1'b0;
        overflow_clr = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge adc_clk);
        @(negedge adc_clk);
        compare_all();
        adc_rstn = 1'b1;
    endtask

    logic [M-1:0] r_en;

    initial begin
        adc_rstn = 1'b0;
        @(negedge adc_clk);
        do_reset();
        chk("rst_valid", 64'(pack_valid), 64'd0);
        chk("rst_data",  pack_data,       64'd0);
        chk("rst_ovf",   64'(overflow),   64'd0);

        // Full enable, two complete words.
        step(4'hF, 4'h0, '0, 1'b1, 1'b0);
        step(4'hF, 4'hF, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b0);
        chk("w0_data", pack_data, 64'h0004_0003_0002_0001);
        chk("w0_sof",  64'(pack_sof), 64'd1);
        step(4'hF, 4'hF, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b0);
        chk("w1_data",  pack_data, 64'h0008_0007_0006_0005);
        chk("w1_sof",   64'(pack_sof), 64'd0);
        chk("w1_valid", 64'(pack_valid), 64'd1);
        step(4'hF, 4'h0, '0, 1'b1, 1'b0);

        // Sparse enable: channels 0 and 2.
        step(4'b0101, 4'h0, '0, 1'b1, 1'b0);
        step(4'b0101, 4'b0101, {16'h0, 16'h000B, 16'h0, 16'h000A}, 1'b1, 1'b0);
        chk("sparse_part", 64'(pack_valid), 64'd0);
        step(4'b0101, 4'b0101, {16'h0, 16'h000D, 16'h0, 16'h000C}, 1'b1, 1'b0);
        chk("sparse_word", pack_data, 64'h000D_000C_000B_000A);

        // Stalled consumer: second word dropped.
        @(negedge adc_clk);
        do_reset();
        step(4'b0001, 4'h0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(4'b0001, 4'b0001, {48'h0, 16'(16'h0010 + i)}, 1'b0, 1'b0);
        chk("ovf_held", pack_data, 64'h0013_0012_0011_0010);
        chk("ovf_set",  64'(overflow), 64'd1);
`ifdef RWT_ADC_PACK_STATS_EN
        chk("ovf_drops", 64'(drop_count), 64'd1);
`endif

        // Clear without drop, then clear coinciding with a drop.
        step(4'b0001, 4'h0, '0, 1'b0, 1'b1);
        chk("clr_only", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++)
            step(4'b0001, 4'b0001, {48'h0, 16'(16'h0018 + i)}, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, {48'h0, 16'h001B}, 1'b0, 1'b1);
        chk("clr_vs_drop", 64'(overflow), 64'd1);

        // Reconfiguration discards the partial word.
        step(4'b0011, 4'h0, '0, 1'b1, 1'b0);
        step(4'b0011, 4'b0011, {32'h0, 16'h0022, 16'h0021}, 1'b1, 1'b0);
        step(4'hF, 4'h0, '0, 1'b1, 1'b0);
        step(4'hF, 4'hF, {16'h34, 16'h33, 16'h32, 16'h31}, 1'b1, 1'b0);
        chk("recfg_data", pack_data, 64'h0034_0033_0032_0031);
        chk("recfg_sof",  64'(pack_sof), 64'd1);

        // Reset with three samples pending.
        step(4'b0111, 4'h0, '0, 1'b1, 1'b0);
        step(4'b0111, 4'b0111, {16'h0, 16'h43, 16'h42, 16'h41}, 1'b1, 1'b0);
        do_reset();
        chk("mid_rst_valid", 64'(pack_valid), 64'd0);
        chk("mid_rst_sof",   64'(pack_sof), 64'd0);
        step(4'hF, 4'h0, '0, 1'b1, 1'b0);
        step(4'hF, 4'hF, {16'h54, 16'h53, 16'h52, 16'h51}, 1'b1, 1'b0);
        chk("post_rst_data", pack_data, 64'h0054_0053_0052_0051);
        chk("post_rst_sof",  64'(pack_sof), 64'd1);

        // Randomized traffic.
        r_en = 4'hF;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 24) == 0) r_en = 4'($urandom_range(0, 15));
            step(r_en, 4'($urandom_range(0, 15)), {$urandom, $urandom},
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
